// File: rtl/calc_pkg.sv
// Shared types and limits for the BCD operand-entry block.
package calc_pkg;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int         DEB_CYCLES_DEF = 250000;
  localparam logic [9:0] MAG_MAX_POS    = 10'd255;
  localparam logic [9:0] MAG_MAX_NEG    = 10'd256;

  function automatic logic bcd_ok(input logic [3:0] dig);
    return (dig <= 4'd9);
  endfunction

  // The magnitude has already been range-checked, so 9 bits always suffice.
  function automatic logic [8:0] apply_sign(input logic [9:0] mag, input logic neg);
    logic [8:0] mag9_s;
    mag9_s = mag[8:0];
    return neg ? (9'd0 - mag9_s) : mag9_s;
  endfunction

endpackage

// File: rtl/bcd_entry_if.sv
// Switch/button inputs and operand outputs of the BCD entry block.
interface bcd_entry_if;
  import calc_pkg::*;

  logic [3:0] sw_dig;
  logic       sw_sign;
  logic       btn_enter;
  logic       btn_clear;
  logic [8:0] resultado;
  logic       valid;
  logic [1:0] ndig;
  logic       err;
  logic       busy;

  modport master (
    output sw_dig, sw_sign, btn_enter, btn_clear,
    input  resultado, valid, ndig, err, busy
  );

  modport slave (
    input  sw_dig, sw_sign, btn_enter, btn_clear,
    output resultado, valid, ndig, err, busy
  );

endinterface

// File: rtl/bcd_entry_debouncer.sv
// Two-flop synchronizer, stable-time debouncer and rising-edge event pulse.
module debouncer
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;

  // Level follows the synchronized input only after DEB_CYCLES unbroken cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= 2'b00;
      level_r <= 1'b0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], btn};
      pulse_r <= 1'b0;
      if (sync_r[1] == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= '0;
        pulse_r <= sync_r[1];
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/bcd_entry.sv
// Three-digit signed BCD operand entry: debounced buttons feed a five-state FSM
// that accumulates digits, range-checks the magnitude and emits a signed result.
module bcd_entry
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst,
  bcd_entry_if.slave  bus
);

  logic       ent_ev_s;
  logic       clr_ev_s;
  state_t     state_r;
  logic [9:0] acc_r;
  logic       sign_r;
  logic [1:0] ndig_r;
  logic [8:0] resultado_r;
  logic       valid_r;
  logic       err_r;
  logic       busy_r;
  logic [9:0] acc_next_s;

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk(clk), .rst(rst), .btn(bus.btn_enter), .pulse(ent_ev_s)
  );

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .rst(rst), .btn(bus.btn_clear), .pulse(clr_ev_s)
  );

  assign acc_next_s = (acc_r * 10'd10) + {6'd0, bus.sw_dig};

  // Entry FSM; clear has priority over every other event, and resultado only moves with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_EMPTY;
      acc_r       <= 10'd0;
      sign_r      <= 1'b0;
      ndig_r      <= 2'd0;
      resultado_r <= 9'd0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (clr_ev_s) begin
        state_r <= S_EMPTY;
        acc_r   <= 10'd0;
        sign_r  <= 1'b0;
        ndig_r  <= 2'd0;
        err_r   <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_EMPTY, S_ENTRY, S_DONE: begin
            if (ent_ev_s) begin
              if (!bcd_ok(bus.sw_dig)) begin
                state_r <= S_ERR;
                err_r   <= 1'b1;
              end else if (state_r == S_DONE) begin
                acc_r   <= {6'd0, bus.sw_dig};
                ndig_r  <= 2'd1;
                state_r <= S_ENTRY;
              end else begin
                acc_r  <= acc_next_s;
                ndig_r <= ndig_r + 2'd1;
                if (ndig_r == 2'd2) begin
                  sign_r  <= bus.sw_sign;
                  state_r <= S_CHECK;
                  busy_r  <= 1'b1;
                end else begin
                  state_r <= S_ENTRY;
                end
              end
            end
          end
          S_CHECK: begin
            busy_r <= 1'b0;
            if (sign_r ? (acc_r > MAG_MAX_NEG) : (acc_r > MAG_MAX_POS)) begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end else begin
              resultado_r <= apply_sign(acc_r, sign_r);
              valid_r     <= 1'b1;
              state_r     <= S_DONE;
            end
          end
          S_ERR: begin
            err_r <= 1'b1;
          end
          default: begin
            state_r <= S_EMPTY;
            acc_r   <= 10'd0;
            ndig_r  <= 2'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.resultado = resultado_r;
  assign bus.valid     = valid_r;
  assign bus.ndig      = ndig_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_bcd_entry.sv
// Directed bench for bcd_entry with a short debounce time.
module tb_bcd_entry;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   valid_cnt;
  int   busy_cnt;
  int   v0;
  int   b0;

  bcd_entry_if bus ();

  bcd_entry #(.DEB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with valid / busy high, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.valid) valid_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input logic s);
    bus.sw_dig    = d;
    bus.sw_sign   = s;
    bus.btn_enter = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic clear();
    bus.btn_clear = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    valid_cnt     = 0;
    busy_cnt      = 0;
    bus.sw_dig    = 4'd0;
    bus.sw_sign   = 1'b0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    rst           = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_res", bus.resultado, 9'd0);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_ndig", bus.ndig, 2'd0);
    check("rst_err", bus.err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // +123
    v0 = valid_cnt; b0 = busy_cnt;
    press(4'd1, 1'b0); check("p123_n1", bus.ndig, 2'd1);
    press(4'd2, 1'b0); check("p123_n2", bus.ndig, 2'd2);
    press(4'd3, 1'b0); check("p123_n3", bus.ndig, 2'd3);
    check("p123_res", bus.resultado, 9'h07B);
    check("p123_vcnt", valid_cnt - v0, 1);
    check("p123_bcnt", busy_cnt - b0, 1);
    check("p123_err", bus.err, 1'b0);

    // -256 starting from S_DONE
    v0 = valid_cnt;
    press(4'd2, 1'b1); check("m256_n1", bus.ndig, 2'd1);
    press(4'd5, 1'b1);
    press(4'd6, 1'b1);
    check("m256_res", bus.resultado, 9'h100);
    check("m256_vcnt", valid_cnt - v0, 1);

    // +256 is out of range
    v0 = valid_cnt;
    press(4'd2, 1'b0); press(4'd5, 1'b0); press(4'd6, 1'b0);
    check("p256_err", bus.err, 1'b1);
    check("p256_vcnt", valid_cnt - v0, 0);
    check("p256_res", bus.resultado, 9'h100);
    clear();
    check("p256_clr_err", bus.err, 1'b0);
    check("p256_clr_ndig", bus.ndig, 2'd0);

    // -0 then new digit
    v0 = valid_cnt;
    press(4'd0, 1'b1); press(4'd0, 1'b1); press(4'd0, 1'b1);
    check("m0_res", bus.resultado, 9'd0);
    check("m0_vcnt", valid_cnt - v0, 1);
    press(4'd7, 1'b0);
    check("m0_n7", bus.ndig, 2'd1);
    check("m0_res7", bus.resultado, 9'd0);

    // Illegal digit, enters ignored in S_ERR
    clear();
    press(4'hA, 1'b0);
    check("bad_err", bus.err, 1'b1);
    check("bad_ndig", bus.ndig, 2'd0);
    press(4'd1, 1'b0); press(4'd2, 1'b0);
    check("bad_err2", bus.err, 1'b1);
    check("bad_ndig2", bus.ndig, 2'd0);
    clear();
    check("bad_clr_err", bus.err, 1'b0);
    check("bad_clr_ndig", bus.ndig, 2'd0);

    // Glitch and bounce before a stable press: one event only
    bus.sw_dig = 4'd1;
    bus.btn_enter = 1'b1; repeat (3) @(negedge clk);
    bus.btn_enter = 1'b0; repeat (10) @(negedge clk);
    check("glitch_n0", bus.ndig, 2'd0);
    for (int i = 0; i < 5; i++) begin
      bus.btn_enter = ~bus.btn_enter;
      @(negedge clk);
    end
    bus.btn_enter = 1'b1; repeat (12) @(negedge clk);
    bus.btn_enter = 1'b0; repeat (12) @(negedge clk);
    check("bounce_n1", bus.ndig, 2'd1);
    press(4'd2, 1'b0); press(4'd3, 1'b0);
    check("bounce_res", bus.resultado, 9'h07B);

    // Reset mid-entry
    v0 = valid_cnt;
    press(4'd4, 1'b0); press(4'd5, 1'b0);
    check("rstmid_n2", bus.ndig, 2'd2);
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_ndig", bus.ndig, 2'd0);
    check("rstmid_res", bus.resultado, 9'd0);
    check("rstmid_vcnt", valid_cnt - v0, 0);

    // Clear and enter in the same cycle: clear wins
    press(4'd8, 1'b0);
    check("both_pre", bus.ndig, 2'd1);
    bus.sw_dig = 4'd9;
    bus.btn_enter = 1'b1; bus.btn_clear = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_enter = 1'b0; bus.btn_clear = 1'b0;
    repeat (12) @(negedge clk);
    check("both_ndig", bus.ndig, 2'd0);
    check("both_err", bus.err, 1'b0);

    // Button held through reset gives one event afterwards
    bus.sw_dig = 4'd3;
    bus.btn_enter = 1'b1;
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    check("held_ndig", bus.ndig, 2'd1);
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 The block SHALL take one parameter: DEB_CYCLES, default 250000, the debounce stable-time in clk cycles (5 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sw_dig  input  4  BCD digit from the switches, sampled on an enter event.
REQ-005 sw_sign  input  1  sign switch (1 = negative), sampled on the third enter event.
REQ-006 btn_enter  input  1  raw push-button (asynchronous, bouncing) that commits one digit.
REQ-007 btn_clear  input  1  raw push-button (asynchronous, bouncing) that aborts the entry.
REQ-008 resultado  output  9  signed two's-complement operand, range -256..+255, held until the next valid.
REQ-009 valid  output  1  one-cycle pulse marking a new resultado.
REQ-010 ndig  output  2  number of digits committed so far, 0..3.
REQ-011 err  output  1  high while the block is in S_ERR.
REQ-012 busy  output  1  high while the block is in S_CHECK.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input has been stable for DEB_CYCLES consecutive cycles.
REQ-014 An event SHALL be a single-cycle pulse generated on the rising edge of a debounced level; release generates no event.
REQ-015 The FSM SHALL have five states: S_EMPTY, S_ENTRY, S_CHECK, S_DONE, S_ERR.
REQ-016 On an enter event in S_EMPTY or S_ENTRY with sw_dig > 9, the FSM SHALL go to S_ERR; acc and ndig SHALL be unchanged.
REQ-017 On an enter event in S_EMPTY or S_ENTRY with sw_dig <= 9, the block SHALL update the 10-bit accumulator acc <= acc*10 + sw_dig and increment ndig.
REQ-018 After that update: ndig 1..2 SHALL give S_ENTRY; ndig 3 SHALL latch sw_sign and give S_CHECK.
REQ-019 S_CHECK SHALL last exactly one cycle and SHALL exit as follows:
- sign=0 and acc > 255: go to S_ERR.
- sign=1 and acc > 256: go to S_ERR.
- otherwise: register resultado = sign ? -acc : acc, assert valid for one cycle, go to S_DONE.
REQ-020 Latency: valid SHALL be high on the second rising edge after the edge that registers the third enter event.
REQ-021 An entry of -0 SHALL produce resultado = 0.
REQ-022 An entry of -256 SHALL produce resultado = 9'h100.
REQ-023 An enter event in S_DONE SHALL start a new entry: acc = sw_dig, ndig = 1, state S_ENTRY; sw_dig > 9 in S_DONE SHALL give S_ERR, as in REQ-016.
REQ-024 resultado SHALL keep its old value until the next valid.
REQ-025 In S_ERR, err SHALL be 1 and enter events SHALL be ignored; only a clear event leaves S_ERR.
REQ-026 A clear event in any state SHALL give S_EMPTY with acc = 0, ndig = 0, err = 0; resultado SHALL be unchanged.
REQ-027 A clear event in S_CHECK SHALL suppress valid.
REQ-028 If clear and enter events occur in the same cycle, clear SHALL win and the digit SHALL be discarded.
REQ-029 Enter events arriving while in S_CHECK SHALL be dropped.

Reset
REQ-030 While rst is high, the block SHALL hold: state S_EMPTY, acc 0, sign 0, ndig 0, resultado 0, valid 0, err 0, busy 0, synchronizer and debounced levels 0, debounce counters 0.
REQ-031 Reset asserted mid-entry or during S_CHECK SHALL abort the entry with no valid pulse.
REQ-032 After rst deasserts, a button that is already held SHALL produce one event once the debounce completes.

Structure
REQ-033 The shared package calc_pkg SHALL hold the FSM state enum, DEB_CYCLES_DEF = 250000, MAG_MAX_POS = 255 and MAG_MAX_NEG = 256.
REQ-034 The block SHALL instantiate one sub-module, debouncer, twice (enter, clear); debouncer contains the synchronizer, stable counter and rising-edge pulse.

Verification (DEB_CYCLES = 4)
REQ-035 Digits 1,2,3 with sw_sign=0 -> resultado = 9'h07B (+123), valid high exactly 1 cycle, ndig sequence 1,2,3.
REQ-036 Digits 2,5,6 with sw_sign=1 -> resultado = 9'h100 (-256); digits 2,5,6 with sw_sign=0 -> err = 1, no valid pulse, resultado unchanged.
REQ-037 Digits 0,0,0 with sw_sign=1 -> resultado = 0 and valid pulses; then digit 7 -> ndig = 1, resultado still 0.
REQ-038 Enter with sw_dig = 4'hA -> err = 1; two further enters -> no change; clear -> err = 0, ndig = 0.
REQ-039 btn_enter glitch of 3 cycles plus 5 bounce toggles before a stable press -> exactly one event, ndig increments once.
REQ-040 rst pulse after two digits -> ndig = 0, resultado = 0; clear and enter in the same cycle -> ndig = 0, no digit taken.
